// File: rtl/star_noc_pkg.sv
// Shared definitions for the star hub: parameter defaults, flit field positions, FSM encoding.
package star_noc_pkg;

  localparam int unsigned NPORTS_DEFAULT = 4;
  localparam int unsigned DATA_W_DEFAULT = 64;

  // Flit header fields; the last-flit flag sits in the top bit of the flit.
  localparam int unsigned SRC_LSB  = 0;
  localparam int unsigned SRC_W    = 4;
  localparam int unsigned DEST_LSB = 4;
  localparam int unsigned DEST_W   = 4;

  localparam int unsigned TMO_W    = 8;
  localparam int unsigned STAT_W   = 16;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  function automatic int unsigned last_bit(input int unsigned data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of valid at or after ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned PW     = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] valid,
  input  logic [PW-1:0]     ptr,
  output logic [PW-1:0]     idx,
  output logic              any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Walk offsets from farthest to nearest so the nearest valid port wins.
    for (int off = NPORTS - 1; off >= 0; off--) begin
      int unsigned pos;
      pos = (int'(ptr) + off) % NPORTS;
      if (valid[pos[PW-1:0]]) begin
        idx = pos[PW-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/star_hub_arbiter.sv
// Packet-locked round-robin arbiter feeding the hub buffer from NPORTS leaves.
// Optional per-port packet counters on grant_cnt when STAR_ARB_STATS_EN is defined.
module star_hub_arbiter
  import star_noc_pkg::*;
#(
  parameter int unsigned NPORTS  = NPORTS_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned PW      = $clog2(NPORTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_valid,
  input  logic [NPORTS*DATA_W-1:0] req_data,
  output logic [NPORTS-1:0]        req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DATA_W-1:0]        fifo_din,
  output logic [PW-1:0]            grant_port,
  output logic                     busy,
  output logic                     timeout_err
`ifdef STAR_ARB_STATS_EN
  ,
  output logic [NPORTS*STAT_W-1:0] grant_cnt
`endif
);

  localparam int unsigned LastBit = last_bit(DATA_W);

  arb_state_e       state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              cur_valid;
  logic [DATA_W-1:0] cur_data;
  logic              accept;
  logic              release_hub;
  logic [TMO_W-1:0]  tmo_cnt_inc;
  logic [PW-1:0]     next_ptr;

  rr_pick #(
    .NPORTS (NPORTS),
    .PW     (PW)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant_q == PW'(i)) begin
        cur_valid = req_valid[i];
        cur_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept      = (state_q == StBusy) && cur_valid && !fifo_full;
  assign tmo_cnt_inc = tmo_cnt_q + TMO_W'(1);
  assign next_ptr    = (grant_q == PW'(NPORTS - 1)) ? '0 : grant_q + PW'(1);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = 1'b0;
    release_hub   = 1'b0;
    unique case (state_q)
      StIdle: begin
        tmo_cnt_d = '0;
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (accept) begin
          tmo_cnt_d   = '0;
          release_hub = cur_data[LastBit];
        end else if (!cur_valid && !fifo_full) begin
          // Stalls from a full buffer neither count nor clear the idle counter.
          tmo_cnt_d = tmo_cnt_inc;
          if (tmo_cnt_inc == TMO_W'(TIMEOUT)) begin
            timeout_err_d = 1'b1;
            release_hub   = 1'b1;
          end
        end
        if (release_hub) begin
          state_d   = StIdle;
          rr_ptr_d  = next_ptr;
          tmo_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NPORTS; i++) begin
      req_ready[i] = accept && (grant_q == PW'(i));
    end
  end

  assign fifo_wr_en  = accept;
  assign fifo_din    = accept ? cur_data : '0;
  assign grant_port  = grant_q;
  assign busy        = (state_q == StBusy);
  assign timeout_err = timeout_err_q;

`ifdef STAR_ARB_STATS_EN
  logic [NPORTS-1:0][STAT_W-1:0] grant_cnt_q;

  // Only packets that end with an accepted last flit count as completed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt_q <= '0;
    end else if (accept && cur_data[LastBit]) begin
      if (grant_cnt_q[grant_q] != '1) begin
        grant_cnt_q[grant_q] <= grant_cnt_q[grant_q] + STAT_W'(1);
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_star_hub_arbiter.sv
// Directed self-checking bench for star_hub_arbiter (NPORTS=4, DATA_W=64, TIMEOUT=15).
module tb_star_hub_arbiter;
  import star_noc_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req_valid;
  logic [NP*DW-1:0] req_data;
  logic [NP-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_din;
  logic [1:0]       grant_port;
  logic             busy;
  logic             timeout_err;
`ifdef STAR_ARB_STATS_EN
  logic [NP*16-1:0] grant_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  star_hub_arbiter #(
    .NPORTS  (NP),
    .DATA_W  (DW),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .grant_port  (grant_port),
    .busy        (busy),
    .timeout_err (timeout_err)
`ifdef STAR_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] flit(input logic last, input logic [3:0] dest,
                                       input logic [3:0] src, input logic [7:0] tag);
    logic [63:0] f;
    f = '0;
    f[DW-1] = last;
    f[DEST_LSB +: DEST_W] = dest;
    f[SRC_LSB +: SRC_W] = src;
    f[15:8] = tag;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(input int p, input logic [63:0] v);
    req_data[p*DW +: DW] = v;
  endtask

  // Leaves the bench just after an edge with rr_ptr=0 and the DUT in IDLE.
  task automatic do_reset();
    req_valid = '0;
    fifo_full = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic expect_write(input string tag, input int p, input logic [63:0] v);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_grant"}, 64'(grant_port), 64'(p));
    check({tag, "_wr"}, 64'(fifo_wr_en), 64'd1);
    check({tag, "_din"}, fifo_din, v);
    check({tag, "_ready"}, 64'(req_ready), 64'(4'b0001 << p));
  endtask

  task automatic expect_nowrite(input string tag);
    check({tag, "_wr"}, 64'(fifo_wr_en), 64'd0);
    check({tag, "_din"}, fifo_din, 64'd0);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
  endtask

  logic [63:0] f1a, f1b, f1c, f2, b1, b2, b3, t0, t1;
  int rr_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset with every leaf requesting: nothing may be accepted.
    rst = 1'b0;
    fifo_full = 1'b0;
    req_valid = 4'hF;
    req_data = '0;
    for (int p = 0; p < NP; p++) set_flit(p, flit(1'b1, 4'h9, 4'(p), 8'(8'hA0 + p)));
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      expect_nowrite("rst");
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_grant", 64'(grant_port), 64'd0);
      check("rst_tmo", 64'(timeout_err), 64'd0);
    end

    // Round-robin over single-flit packets, all leaves valid.
    rst = 1'b1;
    #1;
    check("rr_idle0", 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      expect_write($sformatf("rr%0d", i), rr_seq[i], flit(1'b1, 4'h9, 4'(rr_seq[i]),
                   8'(8'hA0 + rr_seq[i])));
      tick();
      #1;
      check($sformatf("rr%0d_idle", i), 64'(busy), 64'd0);
      expect_nowrite($sformatf("rr%0d_gap", i));
    end

    // Packet lock: port 1 three flits, port 2 waiting throughout.
    do_reset();
    f1a = flit(1'b0, 4'h3, 4'h1, 8'h11);
    f1b = flit(1'b0, 4'h3, 4'h1, 8'h12);
    f1c = flit(1'b1, 4'h3, 4'h1, 8'h13);
    f2  = flit(1'b1, 4'h5, 4'h2, 8'h21);
    set_flit(1, f1a);
    set_flit(2, f2);
    req_valid = 4'b0110;
    #1;
    expect_nowrite("lock_idle");
    tick();
    set_flit(1, f1a);
    #1;
    expect_write("lock_f1", 1, f1a);
    tick();
    set_flit(1, f1b);
    #1;
    expect_write("lock_f2", 1, f1b);
    tick();
    set_flit(1, f1c);
    #1;
    expect_write("lock_f3", 1, f1c);
    tick();
    req_valid = 4'b0100;
    #1;
    check("lock_rel_busy", 64'(busy), 64'd0);
    expect_nowrite("lock_rel");
    tick();
    #1;
    expect_write("lock_p2", 2, f2);
    tick();
    req_valid = '0;

    // Backpressure mid-packet on port 3.
    do_reset();
    b1 = flit(1'b0, 4'h7, 4'h3, 8'h31);
    b2 = flit(1'b0, 4'h7, 4'h3, 8'h32);
    b3 = flit(1'b1, 4'h7, 4'h3, 8'h33);
    set_flit(3, b1);
    req_valid = 4'b1000;
    tick();
    #1;
    expect_write("bp_b1", 3, b1);
    tick();
    set_flit(3, b2);
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      expect_nowrite($sformatf("bp_full%0d", c));
      check($sformatf("bp_tmo%0d", c), 64'(timeout_err), 64'd0);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    expect_write("bp_b2", 3, b2);
    tick();
    // Idle leaf while the buffer is full must not run the timeout.
    req_valid = '0;
    fifo_full = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    #1;
    check("bp_idlefull_tmo", 64'(timeout_err), 64'd0);
    check("bp_idlefull_busy", 64'(busy), 64'd1);
    tick();
    fifo_full = 1'b0;
    req_valid = 4'b1000;
    set_flit(3, b3);
    #1;
    expect_write("bp_b3", 3, b3);
    tick();
    req_valid = '0;
    #1;
    check("bp_done", 64'(busy), 64'd0);

    // Timeout: port 0 stalls mid-packet, port 1 waits.
    do_reset();
    t0 = flit(1'b0, 4'h1, 4'h0, 8'h41);
    t1 = flit(1'b1, 4'h2, 4'h1, 8'h51);
    set_flit(0, t0);
    set_flit(1, t1);
    req_valid = 4'b0011;
    tick();
    #1;
    expect_write("tmo_first", 0, t0);
    tick();
    req_valid = 4'b0010;
    for (int k = 1; k <= 15; k++) begin
      #1;
      if (timeout_err !== 1'b0 || busy !== 1'b1 || fifo_wr_en !== 1'b0)
        check($sformatf("tmo_wait%0d", k), {61'd0, timeout_err, busy, fifo_wr_en}, 64'b010);
      tick();
    end
    #1;
    check("tmo_pulse", 64'(timeout_err), 64'd1);
    check("tmo_idle", 64'(busy), 64'd0);
    tick();
    #1;
    check("tmo_clear", 64'(timeout_err), 64'd0);
    expect_write("tmo_next", 1, t1);
    tick();
    req_valid = '0;

    // Reset mid-packet abandons it immediately.
    do_reset();
    set_flit(1, f1a);
    req_valid = 4'b0010;
    tick();
    #1;
    expect_write("mid_f1", 1, f1a);
    rst = 1'b0;
    #1;
    expect_nowrite("mid_rst");
    check("mid_rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b1;
    req_valid = '0;

`ifdef STAR_ARB_STATS_EN
    do_reset();
    set_flit(2, f2);
    req_valid = 4'b0100;
    for (int c = 0; c < 6; c++) tick();
    req_valid = '0;
    #1;
    check("stat_p0", 64'(grant_cnt[15:0]), 64'd0);
    check("stat_p1", 64'(grant_cnt[31:16]), 64'd0);
    check("stat_p2", 64'(grant_cnt[47:32]), 64'd3);
    check("stat_p3", 64'(grant_cnt[63:48]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
